// File: rtl/conn_cfg_pkg.sv
// Shared types and constants for the connection configuration table loader.
package conn_cfg_pkg;

    // Image layout: header words, then fixed-size records, then one trailer word
    localparam int HDR_WORDS = 4;
    localparam int REC_WORDS = 7;

    // Header word offsets
    localparam logic [1:0] HDR_MAGIC   = 2'd0;
    localparam logic [1:0] HDR_VERSION = 2'd1;
    localparam logic [1:0] HDR_COUNT   = 2'd2;
    localparam logic [1:0] HDR_TSTAMP  = 2'd3;

    // Record word offsets
    localparam logic [2:0] REC_SWITCH_ID   = 3'd0;
    localparam logic [2:0] REC_MY_IP       = 3'd1;
    localparam logic [2:0] REC_PEER_IP     = 3'd2;
    localparam logic [2:0] REC_PORTS       = 3'd3;
    localparam logic [2:0] REC_MY_MAC_LO   = 3'd4;
    localparam logic [2:0] REC_MAC_MID     = 3'd5;
    localparam logic [2:0] REC_PEER_MAC_HI = 3'd6;

    // Load failure causes reported on err_code
    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_MAGIC    = 3'd1;
    localparam logic [2:0] ERR_VERSION  = 3'd2;
    localparam logic [2:0] ERR_COUNT    = 3'd3;
    localparam logic [2:0] ERR_CHECKSUM = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_REC,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } load_state_e;

    typedef struct packed {
        logic [31:0] switch_id;
        logic [31:0] my_ip;
        logic [31:0] peer_ip;
        logic [15:0] my_port;
        logic [15:0] peer_port;
        logic [47:0] my_mac;
        logic [47:0] peer_mac;
    } conn_rec_t;

    // True in the states that are walking the image in memory
    function automatic logic is_loading(input load_state_e s);
        return (s == ST_HDR) || (s == ST_REC) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/conn_peer_search.sv
// Sequential peer-IP search over the loaded connection table, one entry per cycle.
module conn_peer_search
    import conn_cfg_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [31:0]      ip,
    input  logic             active,
    input  logic [IDX_W:0]   count,
    output logic [IDX_W-1:0] rd_index,
    input  logic [31:0]      rd_peer_ip,
    output logic             done,
    output logic             hit,
    output logic [IDX_W-1:0] index
);

    logic             searching_q;
    logic [IDX_W:0]   cnt_q;
    logic [31:0]      ip_q;
    logic             match;
    logic             last_entry;

    assign rd_index   = cnt_q[IDX_W-1:0];
    assign match      = (rd_peer_ip == ip_q);
    assign last_entry = ((cnt_q + 1'b1) == count);

    // Accept a request, then compare one entry per cycle until a match or the end of the table
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            searching_q <= 1'b0;
            cnt_q       <= '0;
            ip_q        <= '0;
            done        <= 1'b0;
            hit         <= 1'b0;
            index       <= '0;
        end else begin
            done <= 1'b0;
            if (searching_q) begin
                if (!active) begin
                    searching_q <= 1'b0;
                    done        <= 1'b1;
                    hit         <= 1'b0;
                    index       <= '0;
                end else if (match) begin
                    searching_q <= 1'b0;
                    done        <= 1'b1;
                    hit         <= 1'b1;
                    index       <= rd_index;
                end else if (last_entry) begin
                    searching_q <= 1'b0;
                    done        <= 1'b1;
                    hit         <= 1'b0;
                    index       <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (req) begin
                if (!active || (count == '0)) begin
                    done  <= 1'b1;
                    hit   <= 1'b0;
                    index <= '0;
                end else begin
                    searching_q <= 1'b1;
                    cnt_q       <= '0;
                    ip_q        <= ip;
                end
            end
        end
    end

endmodule

// File: rtl/conn_table_loader.sv
// Walks a connection configuration image in memory, validates it and serves table lookups and peer searches.
module conn_table_loader
    import conn_cfg_pkg::*;
#(
    parameter int                    MAX_CONN    = 64,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter logic [31:0]           MAGIC       = 32'h4650_4741,
    parameter logic [31:0]           EXP_VERSION = 32'd1,
    parameter int                    MEM_LATENCY = 1,
    localparam int                   IDX_W       = $clog2(MAX_CONN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata,
    input  logic                  start,
    output logic                  busy,
    output logic                  config_valid,
    output logic                  load_error,
    output logic [2:0]            err_code,
    output logic [IDX_W:0]        conn_count,
    output logic [31:0]           hdr_timestamp,
    input  logic                  lkp_req,
    input  logic [IDX_W-1:0]      lkp_index,
    output logic                  lkp_ack,
    output logic                  lkp_hit,
    output logic [31:0]           lkp_switch_id,
    output logic [31:0]           lkp_my_ip,
    output logic [31:0]           lkp_peer_ip,
    output logic [15:0]           lkp_my_port,
    output logic [15:0]           lkp_peer_port,
    output logic [47:0]           lkp_my_mac,
    output logic [47:0]           lkp_peer_mac,
    input  logic                  srch_req,
    input  logic [31:0]           srch_ip,
    output logic                  srch_done,
    output logic                  srch_hit,
    output logic [IDX_W-1:0]      srch_index
);

    load_state_e           state_q, state_d;
    logic [2:0]            fail_code;
    logic                  pending_q;
    logic [2:0]            wait_cnt_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [1:0]            hdr_word_q;
    logic [2:0]            rec_word_q;
    logic [IDX_W:0]        rec_idx_q;
    logic [IDX_W:0]        count_q;
    logic [31:0]           csum_q;
    conn_rec_t             stage_q;
    conn_rec_t             new_rec;
    conn_rec_t             lkp_rec_q;
    conn_rec_t             conn_table [MAX_CONN];

    logic                  data_valid;
    logic                  in_load;
    logic                  stay_load;
    logic                  issue;
    logic                  start_load;
    logic                  rec_last_word;
    logic                  rec_last_entry;
    logic                  table_we;
    logic                  lkp_in_range;
    logic [IDX_W-1:0]      srch_rd_index;
    logic [31:0]           srch_rd_peer_ip;

    // A read returns exactly MEM_LATENCY cycles after its strobe; only one is ever in flight
    assign data_valid     = pending_q && (wait_cnt_q == 3'(MEM_LATENCY));
    assign in_load        = is_loading(state_q);
    assign stay_load      = is_loading(state_d);
    assign issue          = in_load && stay_load && (!pending_q || data_valid);
    assign start_load     = !in_load && start;
    assign rec_last_word  = (int'(rec_word_q) == REC_WORDS - 1);
    assign rec_last_entry = ((rec_idx_q + 1'b1) == count_q);
    assign table_we       = (state_q == ST_REC) && data_valid && rec_last_word;
    assign lkp_in_range   = ({1'b0, lkp_index} < conn_count);

    // The last record word completes the entry, so it bypasses the staging register
    always_comb begin
        new_rec                 = stage_q;
        new_rec.peer_mac[47:16] = mem_rdata;
    end

    // Load state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: header checks stop the walk at the first bad word
    always_comb begin
        state_d   = state_q;
        fail_code = ERR_NONE;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (data_valid) begin
                    case (hdr_word_q)
                        HDR_MAGIC: begin
                            if (mem_rdata != MAGIC) begin
                                state_d   = ST_ERR;
                                fail_code = ERR_MAGIC;
                            end
                        end
                        HDR_VERSION: begin
                            if (mem_rdata != EXP_VERSION) begin
                                state_d   = ST_ERR;
                                fail_code = ERR_VERSION;
                            end
                        end
                        HDR_COUNT: begin
                            if (mem_rdata > 32'(MAX_CONN)) begin
                                state_d   = ST_ERR;
                                fail_code = ERR_COUNT;
                            end
                        end
                        default: begin
                            state_d = (count_q == '0) ? ST_CHK : ST_REC;
                        end
                    endcase
                end
            end
            ST_REC: begin
                if (data_valid && rec_last_word && rec_last_entry) begin
                    state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (data_valid) begin
                    if (mem_rdata == csum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_ERR;
                        fail_code = ERR_CHECKSUM;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory read sequencing, header capture, record assembly, checksum and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd_en     <= 1'b0;
            mem_addr      <= '0;
            rd_addr_q     <= BASE_ADDR;
            pending_q     <= 1'b0;
            wait_cnt_q    <= '0;
            hdr_word_q    <= '0;
            rec_word_q    <= '0;
            rec_idx_q     <= '0;
            count_q       <= '0;
            csum_q        <= '0;
            stage_q       <= '0;
            busy          <= 1'b0;
            config_valid  <= 1'b0;
            load_error    <= 1'b0;
            err_code      <= ERR_NONE;
            conn_count    <= '0;
            hdr_timestamp <= '0;
        end else begin
            mem_rd_en <= issue;
            busy      <= in_load && stay_load;

            if (issue) begin
                mem_addr   <= rd_addr_q;
                rd_addr_q  <= rd_addr_q + ADDR_WIDTH'(4);
                pending_q  <= 1'b1;
                wait_cnt_q <= '0;
            end else if (data_valid) begin
                pending_q <= 1'b0;
            end else if (pending_q) begin
                wait_cnt_q <= wait_cnt_q + 3'd1;
            end

            if (start_load) begin
                rd_addr_q    <= BASE_ADDR;
                pending_q    <= 1'b0;
                hdr_word_q   <= '0;
                rec_word_q   <= '0;
                rec_idx_q    <= '0;
                count_q      <= '0;
                csum_q       <= '0;
                config_valid <= 1'b0;
                load_error   <= 1'b0;
                err_code     <= ERR_NONE;
                conn_count   <= '0;
            end

            if (data_valid && (state_q == ST_HDR)) begin
                csum_q     <= csum_q ^ mem_rdata;
                hdr_word_q <= hdr_word_q + 2'd1;
                if (hdr_word_q == HDR_COUNT) begin
                    count_q <= mem_rdata[IDX_W:0];
                end
                if (hdr_word_q == HDR_TSTAMP) begin
                    hdr_timestamp <= mem_rdata;
                end
            end

            if (data_valid && (state_q == ST_REC)) begin
                csum_q <= csum_q ^ mem_rdata;
                case (rec_word_q)
                    REC_SWITCH_ID:   stage_q.switch_id <= mem_rdata;
                    REC_MY_IP:       stage_q.my_ip     <= mem_rdata;
                    REC_PEER_IP:     stage_q.peer_ip   <= mem_rdata;
                    REC_PORTS: begin
                        stage_q.peer_port <= mem_rdata[31:16];
                        stage_q.my_port   <= mem_rdata[15:0];
                    end
                    REC_MY_MAC_LO:   stage_q.my_mac[31:0] <= mem_rdata;
                    REC_MAC_MID: begin
                        stage_q.my_mac[47:32]  <= mem_rdata[15:0];
                        stage_q.peer_mac[15:0] <= mem_rdata[31:16];
                    end
                    REC_PEER_MAC_HI: stage_q.peer_mac[47:16] <= mem_rdata;
                    default: ;
                endcase
                if (rec_last_word) begin
                    rec_word_q <= '0;
                    rec_idx_q  <= rec_idx_q + 1'b1;
                end else begin
                    rec_word_q <= rec_word_q + 3'd1;
                end
            end

            if ((state_q == ST_CHK) && (state_d == ST_DONE)) begin
                config_valid <= 1'b1;
                conn_count   <= count_q;
            end

            if (in_load && (state_d == ST_ERR)) begin
                load_error <= 1'b1;
                err_code   <= fail_code;
            end
        end
    end

    // Connection table storage; contents are only meaningful below conn_count
    always_ff @(posedge clk) begin
        if (table_we) begin
            conn_table[rec_idx_q[IDX_W-1:0]] <= new_rec;
        end
    end

    // Indexed lookup: registered response with zeroed fields on a miss
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lkp_ack   <= 1'b0;
            lkp_hit   <= 1'b0;
            lkp_rec_q <= '0;
        end else begin
            lkp_ack <= lkp_req;
            if (lkp_req) begin
                if ((state_q == ST_DONE) && lkp_in_range) begin
                    lkp_hit   <= 1'b1;
                    lkp_rec_q <= conn_table[lkp_index];
                end else begin
                    lkp_hit   <= 1'b0;
                    lkp_rec_q <= '0;
                end
            end
        end
    end

    assign lkp_switch_id = lkp_rec_q.switch_id;
    assign lkp_my_ip     = lkp_rec_q.my_ip;
    assign lkp_peer_ip   = lkp_rec_q.peer_ip;
    assign lkp_my_port   = lkp_rec_q.my_port;
    assign lkp_peer_port = lkp_rec_q.peer_port;
    assign lkp_my_mac    = lkp_rec_q.my_mac;
    assign lkp_peer_mac  = lkp_rec_q.peer_mac;

    assign srch_rd_peer_ip = conn_table[srch_rd_index].peer_ip;

    conn_peer_search #(
        .IDX_W (IDX_W)
    ) u_search (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (srch_req),
        .ip         (srch_ip),
        .active     (state_q == ST_DONE),
        .count      (conn_count),
        .rd_index   (srch_rd_index),
        .rd_peer_ip (srch_rd_peer_ip),
        .done       (srch_done),
        .hit        (srch_hit),
        .index      (srch_index)
    );

endmodule

// File: doc/conn_table_loader.md
# conn_table_loader

Parametrised successor to the single-record configuration reader. It DMA-style walks a connection configuration image in word memory and validates header, count and trailer checksum. All records go into an internal table of up to MAX_CONN entries. It then serves indexed lookups and a sequential peer-IP search, so the datapath gets connection parameters without re-reading memory.

## Interface
- MAX_CONN, 64: table depth; IDX_W = $clog2(MAX_CONN).
- ADDR_WIDTH, 32: byte address width of mem_addr.
- BASE_ADDR, 0: byte address of image header.
- MAGIC, 32'h4650_4741: required header word 0.
- EXP_VERSION, 1: required header word 1.
- MEM_LATENCY, 1: cycles from mem_rd_en to mem_rdata valid (1..4).

- clk  in  1  single clock.
- rst_n  in  1  reset; asynchronous, active-low.
- mem_rd_en  out  1  read strobe, one word per strobe.
- mem_addr  out  ADDR_WIDTH  byte address, always 4-aligned.
- mem_rdata  in  32  little-endian word, valid MEM_LATENCY cycles after strobe.
- start  in  1  pulse: (re)load image.
- busy  out  1  load in progress.
- config_valid  out  1  table loaded and checked.
- load_error  out  1  load failed; err_code holds cause.
- err_code  out  3  0 none, 1 magic, 2 version, 3 count>MAX_CONN, 4 checksum.
- conn_count  out  IDX_W+1  records loaded.
- hdr_timestamp  out  32  header word 3.
- lkp_req  in  1  indexed lookup request.
- lkp_index  in  IDX_W  entry to read.
- lkp_ack  out  1  one-cycle response strobe.
- lkp_hit  out  1  index < conn_count and config_valid.
- lkp_switch_id, lkp_my_ip, lkp_peer_ip  out  32 each  entry fields.
- lkp_my_port, lkp_peer_port  out  16 each.
- lkp_my_mac, lkp_peer_mac  out  48 each.
- srch_req  in  1  peer-IP search request.
- srch_ip  in  32  peer IP to match.
- srch_done  out  1  one-cycle completion strobe.
- srch_hit  out  1  match found.
- srch_index  out  IDX_W  lowest matching index.

## Operation
- Image: header words magic, version, count, timestamp. Then count records of 7 words: switch_id, my_ip, peer_ip, {peer_port,my_port}, my_mac[31:0], {peer_mac[15:0],my_mac[47:32]}, peer_mac[47:16]. Then trailer word.
- Trailer check: the XOR of all preceding words must equal the trailer.
- FSM: IDLE -> HDR (4 reads) -> REC (7*count reads) -> CHK (1 read) -> DONE, or ERR.
- Check order: magic after word 0, version after word 1, count after word 2. The first failure goes to ERR immediately with no further reads.
- count = 0 is legal: goes to CHK directly.
- One outstanding read at a time; the next strobe is issued in the cycle after data returns.
- start in IDLE, DONE or ERR: clears config_valid, load_error, err_code and conn_count, then enters HDR. start while busy is ignored.
- Lookups and searches are accepted only in DONE. A request in any other state gets the response strobe with lkp_hit/srch_hit = 0.
- Search scans entries 0..conn_count-1, one per cycle, and stops at the first match. srch_req during a search is ignored.
- lkp_req and srch_req may coincide; both are served independently.

## Timing
- Reset values: all outputs 0, FSM in IDLE, table contents undefined.
- start registered at cycle 0; first mem_rd_en at cycle 1, address BASE_ADDR.
- Cycles per word = MEM_LATENCY+1.
- Load time = (4 + 7*count + 1)*(MEM_LATENCY+1) + 1 cycles to the config_valid rise.
- busy is high from cycle 1 until the cycle config_valid or load_error rises.
- lkp_ack fires 1 cycle after lkp_req, and the fields are registered with it. A miss gives zeroed fields.
- srch_done fires k+2 cycles after srch_req on a hit at index k. On a miss it fires conn_count+1 cycles after.
- Reset mid-load aborts immediately; no partial config_valid.

## Structure
- Package conn_cfg_pkg holds: conn_rec_t struct, err codes, REC_WORDS=7, HDR_WORDS=4, word offsets.
- Sub-module conn_peer_search holds the search counter, compare and done/hit logic, and reads the table through its own index port.

## Test plan
- Valid image, count=2, MEM_LATENCY=1 -> config_valid at cycle 39, conn_count=2, err_code=0.
- Word 0 = 32'hDEAD_BEEF -> load_error, err_code=1, exactly one mem_rd_en issued.
- count=65 with MAX_CONN=64 -> err_code=3 after 3 reads.
- Corrupted trailer -> err_code=4. A second start with a good image then gives config_valid=1.
- lkp_index=1 returns my_port 16'h1389, peer_mac 48'h0A1B2C3D4E5F. lkp_index=5 gives lkp_ack with lkp_hit=0.
- srch_ip equal to entry 1's peer_ip -> srch_done 3 cycles after the request, index 1. Unknown IP -> srch_hit=0 after 3 cycles.
